// File: rtl/float_div_16.sv
// Iterative half-precision floating-point divider (restoring, one quotient bit per clock).
// No denormals, no inf/NaN; overflow and divide-by-zero saturate to the largest magnitude.
module float_div_16 #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int BIAS  = 15
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [EXP_W+MAN_W:0]   data_1_i,
    input  logic [EXP_W+MAN_W:0]   data_2_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    output logic [EXP_W+MAN_W:0]   data_div_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic                   dbz_o,
    output logic                   sat_o
);

    localparam int Q_W = MAN_W + 3;
    localparam int E_W = EXP_W + 3;
    localparam logic [3:0] CNT_INIT = 4'(Q_W - 1);
    localparam logic signed [E_W-1:0] E_MAX = E_W'((1 << EXP_W) - 1);
    localparam logic signed [E_W-1:0] E_ONE = E_W'(1);

    // valid/ready: a transfer happens on a rising edge where valid and ready are both high;
    // the producer holds its data stable from raising valid until that edge.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic                   sgn;
    logic signed [E_W-1:0]  exp_r;
    logic [MAN_W:0]         mb;
    logic [MAN_W+1:0]       rem;
    logic [Q_W-1:0]         q;
    logic [3:0]             cnt;
    logic                   zero_a;
    logic                   zero_b;

    logic [EXP_W-1:0]       e1;
    logic [EXP_W-1:0]       e2;
    logic [MAN_W+2:0]       diff;
    logic                   ge;
    logic [MAN_W+1:0]       rem_nxt;

    logic [MAN_W:0]         m_pre;
    logic                   rnd;
    logic [MAN_W+1:0]       m_rnd;
    logic signed [E_W-1:0]  e_adj;
    logic signed [E_W-1:0]  e_fin;
    logic [EXP_W+MAN_W:0]   res;
    logic                   res_dbz;
    logic                   res_sat;

    assign ready_o = (state == IDLE);
    assign e1 = data_1_i[MAN_W +: EXP_W];
    assign e2 = data_2_i[MAN_W +: EXP_W];

    // One restoring step: subtract the divisor if it fits, then shift the partial remainder.
    always_comb begin
        diff    = {1'b0, rem} - {2'b00, mb};
        ge      = ~diff[MAN_W+2];
        rem_nxt = ge ? {diff[MAN_W:0], 1'b0} : {rem[MAN_W:0], 1'b0};
    end

    always_comb begin
        m_pre = q[Q_W-1:2];
        rnd   = q[1];
        e_adj = exp_r;
        if (!q[Q_W-1]) begin
            m_pre = q[Q_W-2:1];
            rnd   = q[0];
            e_adj = exp_r - E_ONE;
        end
        // A carry out of rounding leaves the low mantissa bits zero; only the exponent moves.
        m_rnd = {1'b0, m_pre} + {{(MAN_W+1){1'b0}}, rnd};
        e_fin = m_rnd[MAN_W+1] ? e_adj + E_ONE : e_adj;

        res     = {sgn, e_fin[EXP_W-1:0], m_rnd[MAN_W-1:0]};
        res_dbz = 1'b0;
        res_sat = 1'b0;
        if (zero_a) begin
            res = '0;
        end else if (zero_b) begin
            res     = {sgn, {(EXP_W+MAN_W){1'b1}}};
            res_dbz = 1'b1;
            res_sat = 1'b1;
        end else if (e_fin > E_MAX) begin
            res     = {sgn, {(EXP_W+MAN_W){1'b1}}};
            res_sat = 1'b1;
        end else if (e_fin < E_ONE) begin
            res = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (valid_i) state_nxt = DIV;
            DIV:     if (cnt == 4'd0) state_nxt = NORM;
            NORM:    state_nxt = DONE;
            DONE:    if (ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sgn        <= 1'b0;
            exp_r      <= '0;
            mb         <= '0;
            rem        <= '0;
            q          <= '0;
            cnt        <= '0;
            zero_a     <= 1'b0;
            zero_b     <= 1'b0;
            data_div_o <= '0;
            valid_o    <= 1'b0;
            dbz_o      <= 1'b0;
            sat_o      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        sgn    <= data_1_i[EXP_W+MAN_W] ^ data_2_i[EXP_W+MAN_W];
                        exp_r  <= E_W'(e1) - E_W'(e2) + E_W'(BIAS);
                        mb     <= {1'b1, data_2_i[MAN_W-1:0]};
                        rem    <= {2'b01, data_1_i[MAN_W-1:0]};
                        q      <= '0;
                        cnt    <= CNT_INIT;
                        zero_a <= (e1 == '0);
                        zero_b <= (e2 == '0);
                    end
                end
                DIV: begin
                    rem <= rem_nxt;
                    q   <= {q[Q_W-2:0], ge};
                    cnt <= cnt - 4'd1;
                end
                NORM: begin
                    data_div_o <= res;
                    dbz_o      <= res_dbz;
                    sat_o      <= res_sat;
                    valid_o    <= 1'b1;
                end
                DONE: begin
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        dbz_o   <= 1'b0;
                        sat_o   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_float_div_16.sv
// Directed bench for float_div_16: hand-computed quotients, latency, handshake and reset.
module tb_float_div_16;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [15:0] data_1_i;
    logic [15:0] data_2_i;
    logic        valid_i;
    logic        ready_o;
    logic [15:0] data_div_o;
    logic        valid_o;
    logic        ready_i;
    logic        dbz_o;
    logic        sat_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [17:0] exp_q[$];
    time t_accept;

    float_div_16 dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .data_1_i   (data_1_i),
        .data_2_i   (data_2_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .data_div_o (data_div_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .dbz_o      (dbz_o),
        .sat_o      (sat_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Issue one operation, wait for its result, check it, and drain it.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_d, input logic exp_dbz, input logic exp_sat,
                          input int hold, input bit toggle);
        int lat;
        int waited;
        logic [17:0] e;
        exp_q.push_back({exp_dbz, exp_sat, exp_d});
        @(negedge clk_i);
        data_1_i = a;
        data_2_i = b;
        valid_i  = 1'b1;
        ready_i  = (hold == 0);
        waited = 0;
        while (!ready_o && waited < 40) begin
            @(negedge clk_i);
            waited++;
        end
        check_eq({tag, "_ready_idle"}, 32'(ready_o), 32'd1);
        @(posedge clk_i);
        t_accept = $time;
        @(negedge clk_i);
        valid_i = 1'b0;
        if (toggle) data_1_i = ~a;
        check_eq({tag, "_busy"}, 32'(ready_o), 32'd0);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk_i);
            lat++;
            #1;
            if (valid_o) break;
            if (toggle && lat == 6) data_1_i = 16'h1234;
        end
        e = exp_q.pop_front();
        check_eq({tag, "_latency"}, 32'(lat), 32'd14);
        check_eq({tag, "_data"}, 32'(data_div_o), 32'(e[15:0]));
        check_eq({tag, "_dbz"}, 32'(dbz_o), 32'(e[17]));
        check_eq({tag, "_sat"}, 32'(sat_o), 32'(e[16]));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk_i);
            #1;
            check_eq({tag, "_hold_valid"}, 32'(valid_o), 32'd1);
            check_eq({tag, "_hold_data"}, 32'(data_div_o), 32'(e[15:0]));
            check_eq({tag, "_hold_ready"}, 32'(ready_o), 32'd0);
        end
        if (hold > 0) begin
            @(negedge clk_i);
            ready_i = 1'b1;
        end
        @(posedge clk_i);
        #1;
        check_eq({tag, "_drained"}, {29'd0, valid_o, dbz_o, sat_o}, 32'd0);
        check_eq({tag, "_ready_after"}, 32'(ready_o), 32'd1);
    endtask

    initial begin
        time t_prev;
        rst_i    = 1'b1;
        data_1_i = 16'h0000;
        data_2_i = 16'h0000;
        valid_i  = 1'b0;
        ready_i  = 1'b1;
        repeat (3) @(negedge clk_i);
        check_eq("reset_state", {14'd0, ready_o, valid_o, data_div_o}, {14'd0, 1'b1, 1'b0, 16'h0000});
        check_eq("reset_flags", {30'd0, dbz_o, sat_o}, 32'd0);
        rst_i = 1'b0;

        run_op("t1_3div2",      16'h4200, 16'h4000, 16'h3E00, 1'b0, 1'b0, 0, 1'b0);
        run_op("one_third",     16'h3C00, 16'h4200, 16'h3555, 1'b0, 1'b0, 0, 1'b0);
        run_op("two_thirds",    16'h4000, 16'h4200, 16'h3955, 1'b0, 1'b0, 0, 1'b0);
        run_op("round_up",      16'h3C00, 16'h3BFF, 16'h3C01, 1'b0, 1'b0, 0, 1'b0);
        run_op("near_two",      16'h3FFF, 16'h3C01, 16'h3FFD, 1'b0, 1'b0, 0, 1'b0);
        run_op("neg_quot",      16'hC400, 16'h3800, 16'hC800, 1'b0, 1'b0, 0, 1'b0);
        run_op("neg_divisor",   16'h4200, 16'hC000, 16'hBE00, 1'b0, 1'b0, 0, 1'b0);
        run_op("neg_zero",      16'h8000, 16'h4000, 16'h0000, 1'b0, 1'b0, 0, 1'b0);
        run_op("underflow",     16'h0400, 16'h7C00, 16'h0000, 1'b0, 1'b0, 0, 1'b0);
        run_op("min_normal",    16'h0400, 16'h3C00, 16'h0400, 1'b0, 1'b0, 0, 1'b0);
        run_op("under_by_norm", 16'h0400, 16'h3C01, 16'h0000, 1'b0, 1'b0, 0, 1'b0);
        run_op("exp31_normal",  16'h7C00, 16'h3C00, 16'h7C00, 1'b0, 1'b0, 0, 1'b0);
        run_op("max_no_sat",    16'h7BFF, 16'h3C00, 16'h7BFF, 1'b0, 1'b0, 0, 1'b0);
        run_op("exp32_sat",     16'h7C00, 16'h3800, 16'h7FFF, 1'b0, 1'b1, 0, 1'b0);
        run_op("overflow",      16'h7BFF, 16'h0400, 16'h7FFF, 1'b0, 1'b1, 0, 1'b0);
        run_op("div_by_zero",   16'hC000, 16'h0000, 16'hFFFF, 1'b1, 1'b1, 0, 1'b0);
        run_op("zero_by_zero",  16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 0, 1'b0);
        run_op("denorm_a",      16'h0001, 16'h3C00, 16'h0000, 1'b0, 1'b0, 0, 1'b0);
        run_op("denorm_b",      16'h3C00, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 0, 1'b0);
        run_op("backpressure",  16'hC400, 16'h3800, 16'hC800, 1'b0, 1'b0, 5, 1'b0);
        run_op("toggle_input",  16'h4200, 16'h4000, 16'h3E00, 1'b0, 1'b0, 0, 1'b1);

        t_prev = t_accept;
        run_op("b2b_second",    16'h3C00, 16'h4200, 16'h3555, 1'b0, 1'b0, 0, 1'b0);
        check_eq("issue_interval", 32'((t_accept - t_prev) / 10), 32'd16);

        // Reset in the middle of a division must abort it without producing output.
        @(negedge clk_i);
        data_1_i = 16'h4200;
        data_2_i = 16'h4000;
        valid_i  = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i = 1'b0;
        repeat (5) @(negedge clk_i);
        check_eq("pre_reset_busy", 32'(ready_o), 32'd0);
        rst_i = 1'b1;
        #1;
        check_eq("reset_mid_ready", 32'(ready_o), 32'd1);
        check_eq("reset_mid_valid", 32'(valid_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (20) begin
            @(negedge clk_i);
            if (valid_o) break;
        end
        check_eq("no_output_after_abort", 32'(valid_o), 32'd0);
        run_op("after_reset",   16'h4200, 16'h4000, 16'h3E00, 1'b0, 1'b0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
